inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Inverse of the instruction decoder: packs ALU instruction fields (opcode, rd, rs, isfloat, src, dst, imm) into a 32-bit instruction word.
- Buffers encoded words in a small FIFO.
- Emits them with a sequential instruction-memory address for the program loader and self-test sequencer.
- Invariant: any word it emits, when decoded, returns the accepted fields (rs/imm subject to the packing rules below).

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, 8, width of the emitted address counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- opcode  in  `ALU_OPCODE (8)  full ALU opcode.
- rd  in  `REGADDR (4)  destination register.
- rs  in  `REGADDR (4)  source register; used only when src=0.
- isfloat  in  1  float operation flag.
- src  in  1  1 = immediate source, 0 = register source.
- dst  in  2  destination select.
- imm  in  `HALF (16)  immediate.
- out_valid  out  1  out_inst/out_addr valid.
- out_ready  in  1  consumer accepts the word.
- out_inst  out  `WORD (32)  encoded instruction.
- out_addr  out  ADDR_W  address for out_inst.
- base_load  in  1  load address counter.
- base_addr  in  ADDR_W  value loaded on base_load.
- level  out  clog2(DEPTH)+1  FIFO occupancy.
- err_trunc  out  1  sticky truncation flag.
- err_clear  in  1  clears err_trunc.

Behaviour:
- Clock and reset are fixed: one clock (clk); rst is synchronous and active-high.
- Packing, always:
  - inst[31:28] = opcode[7:4]
  - inst[27] = isfloat
  - inst[26] = src
  - inst[25:24] = dst
  - inst[23:20] = rd
- Packing when src=1:
  - inst[19:16] = opcode[3:0]
  - inst[15:0] = imm
  - rs is ignored.
- Packing when src=0:
  - inst[19:16] = rs
  - inst[15:12] = opcode[3:0]
  - inst[11:0] = imm[11:0]
  - imm[15:12] is discarded.
- Push: occurs on in_valid && in_ready. in_ready = !rst && (level != DEPTH). No push when full, even if a pop happens in the same cycle.
- Pop: occurs on out_valid && out_ready. out_valid = (level != 0).
- out_inst and out_addr are stable while out_valid && !out_ready.
- Latency: a word pushed in cycle N is presented at the earliest in cycle N+1. There is no combinational in-to-out path.
- Ordering: strict FIFO. Simultaneous push and pop (not full, not empty) leaves level unchanged.
- Pointers: wrap modulo DEPTH.
- Address counter:
  - out_addr equals the counter value.
  - Increments by 1 on each pop, wrapping 2^ADDR_W-1 -> 0.
  - base_load takes priority over a same-cycle increment; the popped word carries the pre-load address.
- err_trunc:
  - Set on any accepted push with src=0 and imm[15:12] != 0.
  - Cleared by err_clear.
  - Set wins over err_clear in the same cycle.
  - The word is still encoded and queued.
- Reset, including mid-operation, takes effect that cycle:
  - Pointers, level, address counter and err_trunc clear to 0.
  - out_valid = 0; out_inst = 0; in_ready = 0 while rst is high.
  - Buffered words are discarded.

Decomposition:
- Shared defines header holds the widths (`WORD, `ALU_OPCODE, `REGADDR, `HALF).
- Add field bit-position constants to the same header: OPHI, FLOAT, SRC, DST, RD, RS/OPLO_IMM, OPLO_REG, IMM; the decoder then uses them as well.
- Packing is a combinational function in this module.
- One natural sub-module: sync_fifo (DEPTH x 32, synchronous reset, level output), reusable elsewhere.

Test Plan:
- src=1 encode: opcode=8'h3A, rd=5, rs=9, isfloat=0, dst=01, imm=16'h1234 -> out_inst=32'h355A1234 one cycle later; err_trunc=0.
- src=0 encode: opcode=8'h47, rd=2, rs=3, isfloat=1, dst=10, imm=16'h0ABC -> out_inst=32'h4A237ABC.
  - Repeat with imm=16'hFABC -> same word, err_trunc=1.
  - err_clear -> err_trunc=0.
- Backpressure, DEPTH=4, out_ready=0, 5 bundles offered -> 4 accepted, in_ready=0, level=4.
  - Then out_ready=1 -> 4 words in order at out_addr 0,1,2,3; fifth bundle accepted once level<4.
- Address wrap, ADDR_W=8: base_load with base_addr=8'hFE, then 3 pops -> out_addr FE, FF, 00.
  - base_load during a pop -> popped word keeps its old address, next word at base_addr.
- Reset mid-operation: 2 words queued, rst high 1 cycle -> out_valid=0, level=0, out_addr=0, err_trunc=0, in_ready=0 during rst; new push after reset emitted at address 0.
- Round-trip: 1000 random bundles through inst_encoder into the decoder -> opcode, rd, isfloat, src, dst match.
  - rs matches when src=0.
  - imm matches exactly when src=1, and in bits [11:0] when src=0.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// rtl/inst_encoder_pkg.sv - shared widths, instruction field positions and field bundle type
// Field positions are shared with the instruction decoder so both sides agree on the layout.
package inst_encoder_pkg;

  localparam int WORD       = 32;
  localparam int ALU_OPCODE = 8;
  localparam int REGADDR    = 4;
  localparam int HALF       = 16;

  localparam int OPHI_HI     = 31;
  localparam int OPHI_LO     = 28;
  localparam int FLOAT       = 27;
  localparam int SRC         = 26;
  localparam int DST_HI      = 25;
  localparam int DST_LO      = 24;
  localparam int RD_HI       = 23;
  localparam int RD_LO       = 20;
  // rs (register form) and opcode low nibble (immediate form) share these bits
  localparam int RS_HI       = 19;
  localparam int RS_LO       = 16;
  localparam int OPLO_IMM_HI = 19;
  localparam int OPLO_IMM_LO = 16;
  localparam int OPLO_REG_HI = 15;
  localparam int OPLO_REG_LO = 12;
  localparam int IMM_HI      = 15;
  localparam int IMM12_HI    = 11;
  localparam int IMM_LO      = 0;

  typedef struct packed {
    logic [ALU_OPCODE-1:0] opcode;
    logic [REGADDR-1:0]    rd;
    logic [REGADDR-1:0]    rs;
    logic                  isfloat;
    logic                  src;
    logic [1:0]            dst;
    logic [HALF-1:0]       imm;
  } alu_fields_t;

endpackage

// File: rtl/inst_encoder_sync_fifo.sv
// rtl/inst_encoder_sync_fifo.sv - synchronous FIFO with occupancy output
// Caller guarantees push only when not full and pop only when not empty.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    wr_d    = push ? wr_q + PTR_W'(1) : wr_q;
    rd_d    = pop  ? rd_q + PTR_W'(1) : rd_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_q];
  assign level = level_q;

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - packs ALU fields into instruction words, queues them, emits with addresses
// Outputs are forced to their reset values combinationally while rst is high.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ALU_OPCODE-1:0]      opcode,
  input  logic [REGADDR-1:0]         rd,
  input  logic [REGADDR-1:0]         rs,
  input  logic                       isfloat,
  input  logic                       src,
  input  logic [1:0]                 dst,
  input  logic [HALF-1:0]            imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD-1:0]            out_inst,
  output logic [ADDR_W-1:0]          out_addr,
  input  logic                       base_load,
  input  logic [ADDR_W-1:0]          base_addr,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err_trunc,
  input  logic                       err_clear
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  function automatic logic [WORD-1:0] pack_inst(input alu_fields_t f);
    logic [WORD-1:0] w;
    w                      = '0;
    w[OPHI_HI:OPHI_LO]     = f.opcode[7:4];
    w[FLOAT]               = f.isfloat;
    w[SRC]                 = f.src;
    w[DST_HI:DST_LO]       = f.dst;
    w[RD_HI:RD_LO]         = f.rd;
    if (f.src) begin
      w[OPLO_IMM_HI:OPLO_IMM_LO] = f.opcode[3:0];
      w[IMM_HI:IMM_LO]           = f.imm;
    end else begin
      w[RS_HI:RS_LO]             = f.rs;
      w[OPLO_REG_HI:OPLO_REG_LO] = f.opcode[3:0];
      w[IMM12_HI:IMM_LO]         = f.imm[11:0];
    end
    return w;
  endfunction

  alu_fields_t       fields;
  logic [WORD-1:0]   inst_enc;
  logic [WORD-1:0]   fifo_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic              push, pop, trunc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  assign fields   = {opcode, rd, rs, isfloat, src, dst, imm};
  assign inst_enc = pack_inst(fields);
  assign trunc    = !src && (imm[HALF-1:12] != '0);

  assign in_ready  = !rst && (fifo_level != LVL_W'(DEPTH));
  assign out_valid = !rst && (fifo_level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (inst_enc),
    .pop   (pop),
    .rdata (fifo_rdata),
    .level (fifo_level)
  );

  // A same-cycle load wins; the popped word has already shown the old address.
  always_comb begin
    addr_d = addr_q;
    if (base_load) begin
      addr_d = base_addr;
    end else if (pop) begin
      addr_d = addr_q + ADDR_W'(1);
    end
    err_d = err_q;
    if (err_clear) begin
      err_d = 1'b0;
    end
    if (push && trunc) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  assign out_inst  = out_valid ? fifo_rdata : '0;
  assign out_addr  = rst ? '0 : addr_q;
  assign level     = rst ? '0 : fifo_level;
  assign err_trunc = !rst && err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed and round-trip checks for inst_encoder
module tb_inst_encoder;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [7:0]  opcode;
  logic [3:0]  rd, rs;
  logic        isfloat, src;
  logic [1:0]  dst;
  logic [15:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic [7:0]  out_addr;
  logic        base_load;
  logic [7:0]  base_addr;
  logic [2:0]  level;
  logic        err_trunc, err_clear;

  int pass_cnt = 0;
  int total_cnt = 0;

  inst_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs(rs), .isfloat(isfloat), .src(src), .dst(dst), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .base_load(base_load), .base_addr(base_addr), .level(level),
    .err_trunc(err_trunc), .err_clear(err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] op, input logic [3:0] d, input logic [3:0] s,
                       input logic f, input logic sr, input logic [1:0] ds, input logic [15:0] im);
    opcode = op; rd = d; rs = s; isfloat = f; src = sr; dst = ds; imm = im;
  endtask

  // Bundle i of the queue tests: opcode 8'h1i, rd=i, src=1, imm=16'h010i
  function automatic logic [31:0] seq_word(input int i);
    return 32'h1400_0100 | (32'(i) << 20) | (32'(i) << 16) | 32'(i);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; base_load = 1'b0; err_clear = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; base_load = 1'b0; base_addr = '0;
    err_clear = 1'b0; drive(8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 16'h0000);
    repeat (2) @(negedge clk);
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else pass_cnt++;
    total_cnt++; if (level !== 3'd0) $display("FAIL reset_level got %0d exp 0", level); else pass_cnt++;
    total_cnt++; if (out_inst !== 32'h0) $display("FAIL reset_out_inst got %h exp 0", out_inst); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b exp 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_addr !== 8'h00) $display("FAIL reset_out_addr got %h exp 00", out_addr); else pass_cnt++;
  endtask

  task automatic test_encode_imm();
    drive(8'h3A, 4'd5, 4'd9, 1'b0, 1'b1, 2'b01, 16'h1234);
    in_valid = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL imm_no_comb_path got %b exp 0", out_valid); else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL imm_out_valid got %b exp 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_inst !== 32'h355A1234) $display("FAIL imm_word got %h exp 355A1234", out_inst); else pass_cnt++;
    total_cnt++; if (err_trunc !== 1'b0) $display("FAIL imm_err got %b exp 0", err_trunc); else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_encode_reg();
    drive(8'h47, 4'd2, 4'd3, 1'b1, 1'b0, 2'b10, 16'h0ABC);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total_cnt++; if (out_inst !== 32'h4A237ABC) $display("FAIL reg_word got %h exp 4A237ABC", out_inst); else pass_cnt++;
    total_cnt++; if (err_trunc !== 1'b0) $display("FAIL reg_err_clean got %b exp 0", err_trunc); else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    imm = 16'hFABC;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total_cnt++; if (out_inst !== 32'h4A237ABC) $display("FAIL trunc_word got %h exp 4A237ABC", out_inst); else pass_cnt++;
    total_cnt++; if (err_trunc !== 1'b1) $display("FAIL trunc_err_set got %b exp 1", err_trunc); else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    total_cnt++; if (err_trunc !== 1'b1) $display("FAIL trunc_err_sticky got %b exp 1", err_trunc); else pass_cnt++;
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    #1;
    total_cnt++; if (err_trunc !== 1'b0) $display("FAIL trunc_err_clear got %b exp 0", err_trunc); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic acc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(8'h10 + 8'(i), 4'(i), 4'h0, 1'b0, 1'b1, 2'b00, 16'h0100 + 16'(i));
      in_valid = 1'b1;
      @(negedge clk);
    end
    drive(8'h14, 4'd4, 4'h0, 1'b0, 1'b1, 2'b00, 16'h0104);
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", in_ready); else pass_cnt++;
    total_cnt++; if (level !== 3'd4) $display("FAIL full_level got %0d exp 4", level); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++; if (level !== 3'd4) $display("FAIL full_hold_level got %0d exp 4", level); else pass_cnt++;
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      total_cnt++; if (out_inst !== seq_word(j)) $display("FAIL drain_word%0d got %h exp %h", j, out_inst, seq_word(j)); else pass_cnt++;
      total_cnt++; if (out_addr !== 8'(j)) $display("FAIL drain_addr%0d got %h exp %h", j, out_addr, 8'(j)); else pass_cnt++;
      if (j == 1) begin
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL fifth_accept got %b exp 1", in_ready); else pass_cnt++;
      end
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    #1;
    total_cnt++; if (level !== 3'd0) $display("FAIL drain_level got %0d exp 0", level); else pass_cnt++;
    total_cnt++; if (in_valid !== 1'b0) $display("FAIL fifth_taken got in_valid %b exp 0", in_valid); else pass_cnt++;
  endtask

  task automatic test_addr_wrap();
    do_reset();
    base_load = 1'b1; base_addr = 8'hFE;
    @(negedge clk);
    base_load = 1'b0;
    #1;
    total_cnt++; if (out_addr !== 8'hFE) $display("FAIL load_addr got %h exp FE", out_addr); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      drive(8'h10 + 8'(i), 4'(i), 4'h0, 1'b0, 1'b1, 2'b00, 16'h0100 + 16'(i));
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    total_cnt++; if (out_addr !== 8'hFE) $display("FAIL wrap_addr0 got %h exp FE", out_addr); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++; if (out_addr !== 8'hFF) $display("FAIL wrap_addr1 got %h exp FF", out_addr); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++; if (out_addr !== 8'h00) $display("FAIL wrap_addr2 got %h exp 00", out_addr); else pass_cnt++;
    total_cnt++; if (out_inst !== seq_word(2)) $display("FAIL wrap_word2 got %h exp %h", out_inst, seq_word(2)); else pass_cnt++;
    base_load = 1'b1; base_addr = 8'h40;
    @(negedge clk);
    base_load = 1'b0; out_ready = 1'b0;
    #1;
    total_cnt++; if (out_addr !== 8'h40) $display("FAIL load_during_pop_addr got %h exp 40", out_addr); else pass_cnt++;
    total_cnt++; if (out_inst !== seq_word(3)) $display("FAIL load_during_pop_word got %h exp %h", out_inst, seq_word(3)); else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(8'h3A, 4'd5, 4'd9, 1'b0, 1'b1, 2'b01, 16'h1234);
    in_valid = 1'b1;
    @(negedge clk);
    drive(8'h47, 4'd2, 4'd3, 1'b1, 1'b0, 2'b10, 16'hF123);
    @(negedge clk);
    drive(8'h55, 4'd1, 4'd1, 1'b0, 1'b1, 2'b00, 16'h0001);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total_cnt++; if (level !== 3'd2) $display("FAIL mid_level_before got %0d exp 2", level); else pass_cnt++;
    total_cnt++; if (err_trunc !== 1'b1) $display("FAIL mid_err_before got %b exp 1", err_trunc); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL mid_rst_in_ready got %b exp 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_inst !== 32'h0) $display("FAIL mid_rst_out_inst got %h exp 0", out_inst); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (level !== 3'd0) $display("FAIL post_rst_level got %0d exp 0", level); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL post_rst_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_addr !== 8'h00) $display("FAIL post_rst_addr got %h exp 00", out_addr); else pass_cnt++;
    total_cnt++; if (err_trunc !== 1'b0) $display("FAIL post_rst_err got %b exp 0", err_trunc); else pass_cnt++;
    drive(8'h3A, 4'd5, 4'd9, 1'b0, 1'b1, 2'b01, 16'h1234);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total_cnt++; if (out_inst !== 32'h355A1234) $display("FAIL post_rst_word got %h exp 355A1234", out_inst); else pass_cnt++;
    total_cnt++; if (out_addr !== 8'h00) $display("FAIL post_rst_word_addr got %h exp 00", out_addr); else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0] op; logic [3:0] d; logic [3:0] s; logic f; logic sr; logic [1:0] ds; logic [15:0] im;
  } bundle_t;

  task automatic test_round_trip();
    bundle_t q[$];
    bundle_t b;
    bundle_t exp;
    bundle_t dec;
    int sent = 0;
    int got = 0;
    int cycles = 0;
    do_reset();
    while (got < 1000 && cycles < 20000) begin
      @(negedge clk);
      b = bundle_t'({$urandom, $urandom});
      drive(b.op, b.d, b.s, b.f, b.sr, b.ds, b.im);
      in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (out_valid && out_ready) begin
        exp = q.pop_front();
        dec.op = {out_inst[31:28], out_inst[26] ? out_inst[19:16] : out_inst[15:12]};
        dec.d  = out_inst[23:20];
        dec.f  = out_inst[27];
        dec.sr = out_inst[26];
        dec.ds = out_inst[25:24];
        dec.s  = exp.sr ? exp.s : out_inst[19:16];
        dec.im = exp.sr ? out_inst[15:0] : {exp.im[15:12], out_inst[11:0]};
        total_cnt++;
        if (dec !== exp) $display("FAIL round_trip%0d got %h exp %h word %h", got, dec, exp, out_inst);
        else pass_cnt++;
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(b);
        sent++;
      end
      cycles++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total_cnt++; if (got != 1000) $display("FAIL round_trip_count got %0d exp 1000", got); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_encode_imm();
    test_encode_reg();
    test_backpressure();
    test_addr_wrap();
    test_reset_mid();
    test_round_trip();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
